steer_ring_n: RTL
=================

STEER_RING_N -- requirements
Module: steer_ring_n

Interface
REQ-001 Parameter N, default 4: number of ring stages and steer outputs; legal range 2..32.
REQ-002 Parameter INIT_POS, default 0: stage index holding the token after reset; legal range 0..N-1.
REQ-003 Parameter CW, default 8: width of the revolution counter.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port init, input, 1: reset, asynchronous and active-high.
REQ-006 Port steerCOMP, input, 1: downstream completion; 1 = steered data consumed, 0 = ready for next DATA.
REQ-007 Port dir, input, 1: rotation direction; 0 = ascending index, 1 = descending index.
REQ-008 Port skip_mask, input, N: bit i = 1 excludes stage i from being steered.
REQ-009 Port steer, output, N: one-hot DATA wavefront or all-zero NULL, registered.
REQ-010 Port pos, output, clog2(N) (minimum 1): token position, registered.
REQ-011 Port wrap, output, 1: one-cycle pulse on a token advance that crosses the ring boundary.
REQ-012 Port revs, output, CW: count of completed revolutions, modulo 2^CW.
REQ-013 Port stall, output, 1: high while a DATA issue is blocked because all stages are masked.

Function
REQ-014 Two states: NULL (steer = 0) and DATA (steer = one-hot); no other state is reachable.
REQ-015 NULL -> DATA: when steerCOMP = 0 and at least one stage is unmasked, next cycle steer = onehot(k) and pos = k, where k = first unmasked index found searching from pos inclusive in direction dir with modulo-N wrap.
REQ-016 NULL with steerCOMP = 1: hold NULL; pos and steer unchanged.
REQ-017 NULL with steerCOMP = 0 and skip_mask all ones: hold NULL, stall = 1; stall = 0 in every other case.
REQ-018 DATA with steerCOMP = 0: hold steer and pos unchanged; changes to skip_mask or dir have no effect until DATA is left.
REQ-019 DATA -> NULL: when steerCOMP = 1, next cycle steer = 0 and pos = (pos + 1) mod N if dir = 0, else (pos - 1) mod N, using dir sampled that cycle; the advance ignores the mask.
REQ-020 wrap = 1 for exactly the cycle after a DATA -> NULL advance from N-1 to 0 (dir = 0) or from 0 to N-1 (dir = 1); otherwise 0.
REQ-021 revs increments by 1 in the same cycle wrap rises, and wraps from 2^CW-1 to 0.
REQ-022 Handshake latency: one cycle from a steerCOMP change to the steer response; a full DATA/NULL cycle takes at least 2 clocks.
REQ-023 steer never carries more than one hot bit and never goes from one hot bit straight to another without an intervening NULL.
REQ-024 A masked stage is skipped only at issue time; a stage masked while it is in DATA completes its handshake normally.

Reset
REQ-025 While init = 1: state = NULL, steer = 0, pos = INIT_POS, wrap = 0, revs = 0, stall = 0, independent of clk.
REQ-026 Deassertion of init mid-DATA discards the wavefront; the first issue after release follows REQ-015 from pos = INIT_POS.

Verification
REQ-027 N=4, mask=0, dir=0, steerCOMP toggled 1/0 per issue: steer = 0001,0000,0010,0000,0100,0000,1000,0000,0001; wrap pulses once; revs = 1.
REQ-028 N=4, dir=1, INIT_POS=0, mask=0: issue order is stages 0,3,2,1,0; wrap pulses on the 0->3 advance.
REQ-029 N=4, mask=0110, dir=0: steered stages follow 0,3,0,3; pos reads 1 after the first ack and 0 after the second.
REQ-030 mask=1111 with steerCOMP=0 gives stall=1 and steer=0; clearing mask bit 2 gives stall=0 and steer=0100 next cycle.
REQ-031 Assert init while steer=0100: steer=0 and pos=INIT_POS immediately (asynchronous); revs=0.
REQ-032 CW=2, 4 revolutions: revs counts 1,2,3,0; a mask change during DATA leaves steer unchanged until steerCOMP=1.

Source files
------------

// File: rtl/steer_ring_n.sv
// Token ring that steers a one-hot DATA wavefront to one of N stages and
// returns to NULL on downstream completion, advancing the token by one stage.
module steer_ring_n #(
    parameter int N        = 4,
    parameter int INIT_POS = 0,
    parameter int CW       = 8,
    localparam int PW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          init,
    input  logic          steerCOMP,
    input  logic          dir,
    input  logic [N-1:0]  skip_mask,
    output logic [N-1:0]  steer,
    output logic [PW-1:0] pos,
    output logic          wrap,
    output logic [CW-1:0] revs,
    output logic          stall
);

    typedef enum logic {S_NULL, S_DATA} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  steer_q, steer_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] revs_q, revs_d;

    logic          found;
    logic [PW-1:0] k;
    int            idx;

    // First unmasked stage, searching from the token in the selected direction.
    always_comb begin
        found = 1'b0;
        k     = pos_q;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (dir) idx = (int'(pos_q) + N - i) % N;
            else     idx = (int'(pos_q) + i) % N;
            if (!found && !skip_mask[idx]) begin
                found = 1'b1;
                k     = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        steer_d = steer_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        revs_d  = revs_q;
        case (state_q)
            S_NULL: begin
                if (!steerCOMP && found) begin
                    state_d    = S_DATA;
                    steer_d    = '0;
                    steer_d[k] = 1'b1;
                    pos_d      = k;
                end
            end
            S_DATA: begin
                // Advance ignores the mask; masking only matters at issue time.
                if (steerCOMP) begin
                    state_d = S_NULL;
                    steer_d = '0;
                    if (dir) begin
                        if (pos_q == '0) begin
                            pos_d  = PW'(N - 1);
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = pos_q - PW'(1);
                        end
                    end else begin
                        if (pos_q == PW'(N - 1)) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = pos_q + PW'(1);
                        end
                    end
                    if (wrap_d) revs_d = revs_q + CW'(1);
                end
            end
            default: state_d = S_NULL;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= S_NULL;
            steer_q <= '0;
            pos_q   <= PW'(INIT_POS);
            wrap_q  <= 1'b0;
            revs_q  <= '0;
        end else begin
            state_q <= state_d;
            steer_q <= steer_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            revs_q  <= revs_d;
        end
    end

    assign stall = !init && (state_q == S_NULL) && !steerCOMP && (&skip_mask);
    assign steer = steer_q;
    assign pos   = pos_q;
    assign wrap  = wrap_q;
    assign revs  = revs_q;

endmodule
